ram_access_arbiter: RTL and testbench

//  Shares the single-port-pair RAM between two requesters (A, B), each issuing one

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_access_arbiter_rr_arbiter2.sv | 26 ++
 rtl/ram_access_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM access arbiter:
// FSM state encodings, requester ids and default widths.
package ram_arb_pkg;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t GRANT = 3'd1;
    localparam state_t WR    = 3'd2;
    localparam state_t RD    = 3'd3;
    localparam state_t DONE  = 3'd4;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_access_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick.
// Ports: req[1:0] in, ptr in (favoured port), gnt[1:0] out, nxt_ptr out.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       nxt_ptr
);

    always_comb begin
        gnt     = 2'b00;
        nxt_ptr = ptr;
        if (req == 2'b11) begin
            gnt = (ptr == PORT_B) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        // After any grant the other port becomes favoured.
        if (|gnt) begin
            nxt_ptr = gnt[1] ? PORT_A : PORT_B;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one RAM between requesters A and B,
// round-robin, sequencing write/WriteReady and read/ReadReady.
// Ports: clock, reset (async active-low); ReqX/WeX/AddrX/WDataX in,
// DoneX/RDataX/ErrX out per port; write/read, WriteAddr/ReadAddr,
// WriteData out and ReadData/WriteReady/ReadReady in on the RAM side.
// Optional macro RAM_ARB_TIMEOUT_EN: abort after TIMEOUT cycles with Err.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WeA,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    output logic              DoneA,
    output logic              DoneB,
    output logic [DATA_W-1:0] RDataA,
    output logic [DATA_W-1:0] RDataB,
    output logic              ErrA,
    output logic              ErrB,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              WriteReady,
    input  logic              ReadReady
);

    state_t state_q, state_d;

    logic              win_q, win_d;
    logic              ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    // A port whose Req was still high at its Done is ignored
    // until it has been seen low for a cycle.
    logic              blk_a_q, blk_a_d;
    logic              blk_b_q, blk_b_d;

    logic [1:0] req_eff;
    logic [1:0] gnt;
    logic       nxt_ptr;
    logic       tmo;
    logic       err_pulse;

    assign req_eff = {ReqB & ~blk_b_q, ReqA & ~blk_a_q};

    rr_arbiter2 u_rr (
        .req     (req_eff),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .nxt_ptr (nxt_ptr)
    );

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             in_acc;
    logic             acc_rdy;

    assign in_acc  = (state_q == WR) || (state_q == RD);
    assign acc_rdy = (state_q == WR) ? WriteReady : ReadReady;
    assign tmo     = in_acc && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = in_acc ? cnt_q + 1'b1 : '0;
        err_d = err_q;
        if (state_q == GRANT) begin
            err_d = 1'b0;
        end else if (tmo && !acc_rdy) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_pulse = err_q;
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign err_pulse  = 1'b0;
    assign unused_tmo = (TIMEOUT == 0);
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req_eff) state_d = GRANT;
            GRANT:   state_d = we_q ? WR : RD;
            WR:      if (WriteReady || tmo) state_d = DONE;
            RD:      if (ReadReady || tmo) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        write     = 1'b0;
        read      = 1'b0;
        WriteAddr = '0;
        ReadAddr  = '0;
        WriteData = '0;
        DoneA     = 1'b0;
        DoneB     = 1'b0;
        unique case (state_q)
            GRANT: begin
                if (we_q) begin
                    WriteAddr = addr_q;
                    WriteData = wdata_q;
                end else begin
                    ReadAddr = addr_q;
                end
            end
            WR: begin
                write     = 1'b1;
                WriteAddr = addr_q;
                WriteData = wdata_q;
            end
            RD: begin
                read     = 1'b1;
                ReadAddr = addr_q;
            end
            DONE: begin
                DoneA = (win_q == PORT_A);
                DoneB = (win_q == PORT_B);
            end
            default: ;
        endcase
    end

    assign ErrA   = DoneA & err_pulse;
    assign ErrB   = DoneB & err_pulse;
    assign RDataA = rdata_a_q;
    assign RDataB = rdata_b_q;

    // Request latch, pointer, read data and hold-off flags
    always_comb begin
        win_d     = win_q;
        ptr_d     = ptr_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        blk_a_d   = blk_a_q & ReqA;
        blk_b_d   = blk_b_q & ReqB;
        if (state_q == IDLE && |req_eff) begin
            win_d   = gnt[1];
            ptr_d   = nxt_ptr;
            we_d    = gnt[1] ? WeB : WeA;
            addr_d  = gnt[1] ? AddrB : AddrA;
            wdata_d = gnt[1] ? WDataB : WDataA;
        end
        if (state_q == RD && ReadReady) begin
            if (win_q == PORT_B) begin
                rdata_b_d = ReadData;
            end else begin
                rdata_a_d = ReadData;
            end
        end
        if (state_q == DONE) begin
            if (win_q == PORT_B) begin
                blk_b_d = ReqB;
            end else begin
                blk_a_d = ReqA;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_q     <= PORT_A;
            ptr_q     <= PORT_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            blk_a_q   <= 1'b0;
            blk_b_q   <= 1'b0;
        end else begin
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            blk_a_q   <= blk_a_d;
            blk_b_q   <= blk_b_d;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed testbench for ram_access_arbiter with a small RAM model
// whose ready flags rise after a programmable number of strobe cycles.
`timescale 1ns/1ps
module tb_ram_access_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ReqA = 1'b0, ReqB = 1'b0;
    logic          WeA = 1'b0, WeB = 1'b0;
    logic [AW-1:0] AddrA = '0, AddrB = '0;
    logic [DW-1:0] WDataA = '0, WDataB = '0;
    logic          DoneA, DoneB, ErrA, ErrB;
    logic [DW-1:0] RDataA, RDataB;
    logic          write, read;
    logic [AW-1:0] WriteAddr, ReadAddr;
    logic [DW-1:0] WriteData, ReadData;
    logic          WriteReady = 1'b0, ReadReady = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    // Strobe cycles before ready rises; 0 means ready never rises.
    int wr_lat  = 1;
    int rd_lat  = 1;
    int wstreak = 0;
    int rstreak = 0;
    bit overlap = 1'b0;

    logic [DW-1:0] mem [16];

    always #5 clock = ~clock;

    ram_access_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset),
        .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
        .AddrA(AddrA), .AddrB(AddrB),
        .WDataA(WDataA), .WDataB(WDataB),
        .DoneA(DoneA), .DoneB(DoneB),
        .RDataA(RDataA), .RDataB(RDataB),
        .ErrA(ErrA), .ErrB(ErrB),
        .write(write), .read(read),
        .WriteAddr(WriteAddr), .ReadAddr(ReadAddr),
        .WriteData(WriteData), .ReadData(ReadData),
        .WriteReady(WriteReady), .ReadReady(ReadReady)
    );

    assign ReadData = mem[ReadAddr];

    always @(negedge clock) begin
        if (write && read) overlap = 1'b1;
        wstreak    = write ? wstreak + 1 : 0;
        rstreak    = read ? rstreak + 1 : 0;
        WriteReady = (wr_lat != 0) && write && (wstreak >= wr_lat);
        ReadReady  = (rd_lat != 0) && read && (rstreak >= rd_lat);
    end

    always @(posedge clock) begin
        if (write && WriteReady) mem[WriteAddr] <= WriteData;
    end

    // Drives one request and records what was seen; no checking here.
    task automatic access(
        input  bit            port,
        input  bit            we,
        input  logic [AW-1:0] addr,
        input  logic [DW-1:0] wd,
        input  bit            hold,
        output int            done_at,
        output int            strb,
        output int            other,
        output logic [DW-1:0] rd,
        output logic          err,
        output logic [AW-1:0] a_seen,
        output logic [DW-1:0] d_seen
    );
        done_at = -1;
        strb    = 0;
        other   = 0;
        rd      = '0;
        err     = 1'b0;
        a_seen  = '0;
        d_seen  = '0;
        @(negedge clock);
        if (port) begin
            ReqB = 1'b1; WeB = we; AddrB = addr; WDataB = wd;
        end else begin
            ReqA = 1'b1; WeA = we; AddrA = addr; WDataA = wd;
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (write || read) begin
                strb++;
                a_seen = write ? WriteAddr : ReadAddr;
                d_seen = WriteData;
            end
            if (port ? DoneA : DoneB) other++;
            if (port ? DoneB : DoneA) begin
                done_at = i;
                rd      = port ? RDataB : RDataA;
                err     = port ? ErrB : ErrA;
                break;
            end
        end
        if (!hold) begin
            if (port) ReqB = 1'b0;
            else ReqA = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_total++;
        if ({DoneA, DoneB, ErrA, ErrB, write, read} !== 6'b0)
            $display("FAIL reset_ctl got %b want 000000",
                     {DoneA, DoneB, ErrA, ErrB, write, read});
        else n_pass++;
        n_total++;
        if ({WriteAddr, ReadAddr, WriteData} !== 16'h0)
            $display("FAIL reset_ram got %h want 0000",
                     {WriteAddr, ReadAddr, WriteData});
        else n_pass++;
        n_total++;
        if ({RDataA, RDataB} !== 16'h0)
            $display("FAIL reset_rdata got %h want 0000",
                     {RDataA, RDataB});
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_total++;
        if ({write, read, DoneA, DoneB} !== 4'b0)
            $display("FAIL idle_no_req got %b want 0000",
                     {write, read, DoneA, DoneB});
        else n_pass++;
    endtask

    task automatic test_write_single();
        int d, s, o;
        logic [DW-1:0] r, dd;
        logic e;
        logic [AW-1:0] a;
        wr_lat = 2;
        access(1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, d, s, o, r, e, a, dd);
        n_total++;
        if (s !== 2) $display("FAIL wr_strobe_cycles got %0d want 2", s);
        else n_pass++;
        n_total++;
        if (d !== 4) $display("FAIL wr_done_latency got %0d want 4", d);
        else n_pass++;
        n_total++;
        if (o !== 0) $display("FAIL wr_doneb got %0d want 0", o);
        else n_pass++;
        n_total++;
        if ({a, dd} !== {4'd3, 8'h5A})
            $display("FAIL wr_addr_data got %h/%h want 3/5a", a, dd);
        else n_pass++;
        n_total++;
        if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e);
        else n_pass++;
        wr_lat = 1;
    endtask

    task automatic test_write_read();
        int d, s, o;
        logic [DW-1:0] r, dd;
        logic e;
        logic [AW-1:0] a;
        access(1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, d, s, o, r, e, a, dd);
        n_total++;
        if (d !== 3) $display("FAIL min_latency got %0d want 3", d);
        else n_pass++;
        access(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, d, s, o, r, e, a, dd);
        n_total++;
        if (r !== 8'h5A) $display("FAIL rd_b_at_done got %h want 5a", r);
        else n_pass++;
        n_total++;
        if ({a, s} !== {4'd3, 32'd1})
            $display("FAIL rd_addr_cycles got %h/%0d want 3/1", a, s);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if ({RDataB, RDataA} !== 16'h5A00)
            $display("FAIL rdata_hold got %h want 5a00", {RDataB, RDataA});
        else n_pass++;
    endtask

    task automatic test_alternate();
        int order [4];
        int k = 0, na = 0, nb = 0;
        bit ra = 1'b0, rb = 1'b0;
        @(negedge clock);
        WeA = 1'b0; AddrA = 4'd3;
        WeB = 1'b0; AddrB = 4'd3;
        ReqA = 1'b1; ReqB = 1'b1;
        for (int i = 0; i < 80 && k < 4; i++) begin
            @(negedge clock);
            if (ra) begin ReqA = 1'b1; ra = 1'b0; end
            if (rb) begin ReqB = 1'b1; rb = 1'b0; end
            if (DoneA) begin
                order[k] = 0; k++; na++;
                ReqA = 1'b0; ra = (na < 2);
            end
            if (DoneB) begin
                order[k] = 1; k++; nb++;
                ReqB = 1'b0; rb = (nb < 2);
            end
        end
        ReqA = 1'b0; ReqB = 1'b0;
        n_total++;
        if (k !== 4) $display("FAIL alt_done_count got %0d want 4", k);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_total++;
            if (k > j && order[j] !== (j % 2))
                $display("FAIL alt_grant_%0d got %0d want %0d",
                         j, order[j], j % 2);
            else if (k > j) n_pass++;
            else $display("FAIL alt_grant_%0d got none want %0d", j, j % 2);
        end
        @(negedge clock);
        n_total++;
        if ({RDataA, RDataB} !== 16'h5A5A)
            $display("FAIL alt_rdata got %h want 5a5a", {RDataA, RDataB});
        else n_pass++;
    endtask

    task automatic test_hold();
        int d, s, o, busy = 0, dn = 0, again = -1;
        logic [DW-1:0] r, dd;
        logic e;
        logic [AW-1:0] a;
        access(1'b1, 1'b1, 4'd5, 8'hC3, 1'b1, d, s, o, r, e, a, dd);
        n_total++;
        if (d !== 3) $display("FAIL hold_first got %0d want 3", d);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (write || read) busy++;
            if (DoneB) dn++;
        end
        n_total++;
        if ({busy, dn} !== 64'd0)
            $display("FAIL hold_ignored got %0d/%0d want 0/0", busy, dn);
        else n_pass++;
        ReqB = 1'b0;
        @(negedge clock);
        ReqB = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (DoneB) begin again = i; break; end
        end
        ReqB = 1'b0;
        n_total++;
        if (again !== 3) $display("FAIL hold_regrant got %0d want 3", again);
        else n_pass++;
        n_total++;
        if (mem[5] !== 8'hC3) $display("FAIL hold_mem got %h want c3", mem[5]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = -1, first = -1, at = -1;
        bit a_on, b_on;
        wr_lat = 0;
        @(negedge clock);
        ReqA = 1'b1; WeA = 1'b1; AddrA = 4'd7; WDataA = 8'h11;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (write) begin seen = i; break; end
        end
        n_total++;
        if (seen !== 2) $display("FAIL rst_wr_entry got %0d want 2", seen);
        else n_pass++;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({write, DoneA} !== 2'b00)
            $display("FAIL rst_async got %b want 00", {write, DoneA});
        else n_pass++;
        n_total++;
        if ({RDataA, RDataB} !== 16'h0)
            $display("FAIL rst_rdata got %h want 0000", {RDataA, RDataB});
        else n_pass++;
        ReqA = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        wr_lat = 1;
        @(negedge clock);
        WeA = 1'b0; AddrA = 4'd3; WeB = 1'b0; AddrB = 4'd3;
        ReqA = 1'b1; ReqB = 1'b1;
        a_on = 1'b1; b_on = 1'b1;
        for (int i = 1; i <= 30 && (a_on || b_on); i++) begin
            @(negedge clock);
            if (DoneA) begin
                if (first < 0) begin first = 0; at = i; end
                ReqA = 1'b0; a_on = 1'b0;
            end
            if (DoneB) begin
                if (first < 0) begin first = 1; at = i; end
                ReqB = 1'b0; b_on = 1'b0;
            end
        end
        ReqA = 1'b0; ReqB = 1'b0;
        n_total++;
        if ({first, at} !== {32'd0, 32'd3})
            $display("FAIL rst_ptr_a got port %0d at %0d want 0 at 3",
                     first, at);
        else n_pass++;
        n_total++;
        if (mem[7] === 8'h11) $display("FAIL rst_no_write got 11 want not 11");
        else n_pass++;
    endtask

`ifdef RAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int d, s, o;
        logic [DW-1:0] r, dd;
        logic e;
        logic [AW-1:0] a;
        rd_lat = 0;
        access(1'b0, 1'b0, 4'd9, 8'h00, 1'b0, d, s, o, r, e, a, dd);
        n_total++;
        if ({s, d} !== {32'd16, 32'd18})
            $display("FAIL tmo_cycles got %0d/%0d want 16/18", s, d);
        else n_pass++;
        n_total++;
        if ({e, r} !== {1'b1, 8'h5A})
            $display("FAIL tmo_err_rdata got %b/%h want 1/5a", e, r);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if ({ErrA, DoneA, RDataA} !== {2'b00, 8'h5A})
            $display("FAIL tmo_pulse got %b%b/%h want 00/5a",
                     ErrA, DoneA, RDataA);
        else n_pass++;
        rd_lat = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_write_single();
        test_write_read();
        test_alternate();
        test_hold();
        test_reset_mid();
`ifdef RAM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        n_total++;
        if (overlap !== 1'b0) $display("FAIL strobe_overlap got 1 want 0");
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
